icache_refill_seq: RTL

//  Write-side fill engine for the vanilla-core icache. On an icache miss it fetches the missing block word by word from memory.
//  It streams the words into the icache write port strictly in block-offset order: offset 0..B-1, contiguous, one write per word.

---
 rtl/icache_refill_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/icache_refill_seq.sv
// Icache refill sequencer: on a miss, requests the block word by word from memory
// and streams responses into the icache write port in offset order 0..B-1.
module icache_refill_seq #(
    parameter  int icache_tag_width_p           = 12,
    parameter  int icache_entries_p             = 1024,
    parameter  int icache_block_size_in_words_p = 4,
    parameter  int max_out_p                    = 4,
    localparam int pc_width_lp  = icache_tag_width_p + $clog2(icache_entries_p),
    localparam int off_width_lp = $clog2(icache_block_size_in_words_p),
    localparam int cnt_width_lp = $clog2(max_out_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   miss_v_i,
    input  logic [pc_width_lp-1:0] miss_pc_i,
    output logic                   miss_yumi_o,
    output logic                   mem_req_v_o,
    output logic [pc_width_lp-1:0] mem_req_addr_o,
    input  logic                   mem_req_ready_i,
    input  logic                   mem_resp_v_i,
    input  logic [31:0]            mem_resp_data_i,
    output logic                   mem_resp_yumi_o,
    output logic                   icache_v_o,
    output logic                   icache_w_o,
    output logic [pc_width_lp-1:0] icache_w_pc_o,
    output logic [31:0]            icache_w_instr_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // state | meaning
    // IDLE  | waiting for a miss; accepts it and latches the block base
    // FILL  | issuing block requests and writing responses into the icache
    // DONE  | one-cycle commit pulse, then back to IDLE

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    localparam logic [off_width_lp:0]   blk_lp     = (off_width_lp+1)'(icache_block_size_in_words_p);
    localparam logic [off_width_lp:0]   last_lp    = (off_width_lp+1)'(icache_block_size_in_words_p - 1);
    localparam logic [off_width_lp:0]   off_one_lp = (off_width_lp+1)'(1);
    localparam logic [cnt_width_lp-1:0] max_out_lp = cnt_width_lp'(max_out_p);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

    state_e                  state_q, state_d;
    logic [pc_width_lp-1:0]  base_q, base_d;
    logic [off_width_lp:0]   req_off_q, req_off_d;
    logic [off_width_lp:0]   wr_off_q, wr_off_d;
    logic [cnt_width_lp-1:0] out_cnt_q, out_cnt_d;
    logic                    req_hs, resp_hs;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_off_q <= '0;
            wr_off_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_off_q <= req_off_d;
            wr_off_q  <= wr_off_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        req_off_d        = req_off_q;
        wr_off_d         = wr_off_q;
        out_cnt_d        = out_cnt_q;
        req_hs           = 1'b0;
        resp_hs          = 1'b0;
        miss_yumi_o      = 1'b0;
        mem_req_v_o      = 1'b0;
        mem_req_addr_o   = '0;
        mem_resp_yumi_o  = 1'b0;
        icache_v_o       = 1'b0;
        icache_w_o       = 1'b0;
        icache_w_pc_o    = '0;
        icache_w_instr_o = '0;
        done_o           = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gate with reset so nothing is acknowledged while reset is held.
                miss_yumi_o = miss_v_i & ~reset_i;
                if (miss_yumi_o) begin
                    base_d    = {miss_pc_i[pc_width_lp-1:off_width_lp], {off_width_lp{1'b0}}};
                    req_off_d = '0;
                    wr_off_d  = '0;
                    out_cnt_d = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                mem_req_v_o = (req_off_q < blk_lp) && (out_cnt_q < max_out_lp);
                if (mem_req_v_o)
                    mem_req_addr_o = base_q | pc_width_lp'(req_off_q[off_width_lp-1:0]);
                req_hs = mem_req_v_o & mem_req_ready_i;
                // A response with nothing outstanding is an error; drop it.
                resp_hs         = mem_resp_v_i && (out_cnt_q != '0);
                mem_resp_yumi_o = resp_hs;
                if (req_hs)
                    req_off_d = req_off_q + off_one_lp;
                if (resp_hs) begin
                    icache_v_o       = 1'b1;
                    icache_w_o       = 1'b1;
                    icache_w_pc_o    = base_q | pc_width_lp'(wr_off_q[off_width_lp-1:0]);
                    icache_w_instr_o = mem_resp_data_i;
                    wr_off_d         = wr_off_q + off_one_lp;
                    if (wr_off_q == last_lp)
                        state_d = DONE;
                end
                if (req_hs && !resp_hs)
                    out_cnt_d = out_cnt_q + cnt_one_lp;
                else if (!req_hs && resp_hs)
                    out_cnt_d = out_cnt_q - cnt_one_lp;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

    a_resp_expected: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_v_i |-> (state_q == FILL && out_cnt_q != '0));
    a_out_cnt_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        out_cnt_q <= max_out_lp);

endmodule
